dmem_responder: RTL and testbench

- Data-memory responder that sits on the data-side port of the rv32is core.
- It services the core's load/store requests: byte, halfword and word accesses, with sign or zero extension on loads.
- It flags misaligned and illegal accesses.
- It exposes a "watch" register that captures stores to a fixed address. Benches use this to observe register values.
- Single clock domain. The core's read-clock and write-clock strobes are replaced by request enables on one clock.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 67 ++++++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared access-type constants and legality/alignment helpers
//            for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic [2:0] op, input logic we);
        case (op)
            OP_B, OP_H, OP_W: return 1'b1;
            OP_BU, OP_HU:     return ~we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] addr2);
        case (op[1:0])
            2'b01:   return ~addr2[0];
            2'b10:   return (addr2 == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Byte-lane steering: store byte enables / replicated data and
//            load lane selection with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_st_op,
    input  logic [1:0]  i_st_addr,
    input  logic [31:0] i_datain,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_ld_addr,
    input  logic [31:0] i_rdword,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_datain;
        case (i_st_op[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_st_addr;
                o_wdata = {4{i_datain[7:0]}};
            end
            2'b01: begin
                o_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_datain[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_datain;
            end
        endcase
    end

    always_comb begin
        w_byte = i_rdword[7:0];
        case (i_ld_addr)
            2'b00:   w_byte = i_rdword[7:0];
            2'b01:   w_byte = i_rdword[15:8];
            2'b10:   w_byte = i_rdword[23:16];
            default: w_byte = i_rdword[31:24];
        endcase
        w_half = i_ld_addr[1] ? i_rdword[31:16] : i_rdword[15:0];
    end

    always_comb begin
        o_rdata = i_rdword;
        case (i_ld_op)
            OP_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            OP_BU:   o_rdata = {24'h000000, w_byte};
            OP_H:    o_rdata = {{16{w_half[15]}}, w_half};
            OP_HU:   o_rdata = {16'h0000, w_half};
            default: o_rdata = i_rdword;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-cycle-latency data memory for the rv32is core data port,
//            with fault reporting and a store-watch register.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          AW         = 10,
    parameter logic [31:0] WATCH_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemdatain,
    input  logic [2:0]  dmemop,
    input  logic        dmemwe,
    input  logic        dmemre,
    output logic [31:0] dmemdataout,
    output logic        dmemvalid,
    output logic        fault,
    output logic [31:0] watchdata,
    output logic [15:0] watchcount
);

    localparam int            c_depth     = 2 ** AW;
    localparam logic [AW-1:0] c_watch_idx = WATCH_ADDR[AW+1:2];

    logic [31:0]   r_mem [c_depth];

    logic [AW-1:0] w_idx;
    logic          w_fault;
    logic          w_store;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rdold;
    logic [31:0]   w_merged;
    logic [31:0]   w_ext;
    logic          w_unused_addr;

    logic          r_valid;
    logic          r_fault;
    logic          r_ld_fault;
    logic [2:0]    r_ld_op;
    logic [1:0]    r_ld_addr;
    logic [31:0]   r_rdword;
    logic [31:0]   r_watchdata;
    logic [15:0]   r_watchcount;

    assign w_idx         = dmemaddr[AW+1:2];
    assign w_unused_addr = ^dmemaddr[31:AW+2];
    assign w_fault       = (dmemwe | dmemre)
                         & ~(is_legal(dmemop, dmemwe) & is_aligned(dmemop, dmemaddr[1:0]));
    assign w_store       = dmemwe & ~w_fault & ~reset;
    assign w_rdold       = r_mem[w_idx];

    dmem_lane_align u_lane (
        .i_st_op   (dmemop),
        .i_st_addr (dmemaddr[1:0]),
        .i_datain  (dmemdatain),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_op   (r_ld_op),
        .i_ld_addr (r_ld_addr),
        .i_rdword  (r_rdword),
        .o_rdata   (w_ext)
    );

    generate
        for (genvar g = 0; g < 4; g++) begin : g_merge
            assign w_merged[8*g +: 8] = w_be[g] ? w_wdata[8*g +: 8] : w_rdold[8*g +: 8];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_store) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // The read register samples the pre-write word, giving read-first behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_ld_fault   <= 1'b0;
            r_ld_op      <= OP_W;
            r_ld_addr    <= 2'b00;
            r_rdword     <= 32'h0;
            r_watchdata  <= 32'h0;
            r_watchcount <= 16'h0;
        end else begin
            r_valid <= dmemre;
            r_fault <= w_fault;
            if (dmemre) begin
                r_ld_fault <= w_fault;
                r_ld_op    <= dmemop;
                r_ld_addr  <= dmemaddr[1:0];
                r_rdword   <= w_rdold;
            end
            if (w_store && (w_idx == c_watch_idx)) begin
                r_watchdata <= w_merged;
                if (r_watchcount != 16'hFFFF) begin
                    r_watchcount <= r_watchcount + 16'h1;
                end
            end
        end
    end

    // Reset in the response cycle drops the pending pulse immediately.
    assign dmemvalid   = r_valid & ~reset;
    assign fault       = r_fault & ~reset;
    assign dmemdataout = r_ld_fault ? 32'h0 : w_ext;
    assign watchdata   = r_watchdata;
    assign watchcount  = r_watchcount;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed and randomized checking of dmem_responder against a
//            byte-addressed behavioural memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          AW     = 10;
    localparam int          NBYTES = 1 << (AW + 2);
    localparam logic [31:0] WATCH  = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdatain;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic        dmemre;
    logic [31:0] dmemdataout;
    logic        dmemvalid;
    logic        fault;
    logic [31:0] watchdata;
    logic [15:0] watchcount;

    always #5 clock = ~clock;

    dmem_responder #(.AW(AW), .WATCH_ADDR(WATCH)) dut (
        .clock       (clock),
        .reset       (reset),
        .dmemaddr    (dmemaddr),
        .dmemdatain  (dmemdatain),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dmemre      (dmemre),
        .dmemdataout (dmemdataout),
        .dmemvalid   (dmemvalid),
        .fault       (fault),
        .watchdata   (watchdata),
        .watchcount  (watchcount)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [NBYTES];
    bit          m_known = 1'b0, n_known = 1'b0;
    logic        m_valid, m_fault, n_valid, n_fault;
    logic [31:0] m_dout, m_wd, n_dout, n_wd;
    logic [15:0] m_wc, n_wc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next-cycle outputs derived from byte-level memory semantics.
    task automatic model_step(input logic we, input logic re, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] d, input logic rst);
        int sz, am, w;
        bit legal, aligned, flt;
        logic [31:0] v;
        if (rst) begin
            n_known = 1'b1;
            n_valid = 1'b0; n_fault = 1'b0; n_dout = 32'h0; n_wd = 32'h0; n_wc = 16'h0;
            return;
        end
        sz      = 1 << op[1:0];
        am      = int'(a) & (NBYTES - 1);
        legal   = (op <= 3'd2) || (((op == 3'd4) || (op == 3'd5)) && !we);
        aligned = (am % sz) == 0;
        flt     = (we || re) && !(legal && aligned);
        n_valid = re; n_fault = flt; n_dout = m_dout; n_wd = m_wd; n_wc = m_wc;
        if (re) begin
            if (flt) n_dout = 32'h0;
            else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v |= 32'(mm[(am + i) % NBYTES]) << (8 * i);
                if (!op[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
                n_dout = v;
            end
        end
        if (we && !flt) begin
            for (int i = 0; i < sz; i++) mm[(am + i) % NBYTES] = d[8*i +: 8];
            if ((am / 4) == ((int'(WATCH) & (NBYTES - 1)) / 4)) begin
                w    = (am / 4) * 4;
                n_wd = {mm[w+3], mm[w+2], mm[w+1], mm[w]};
                if (m_wc != 16'hFFFF) n_wc = m_wc + 16'h1;
            end
        end
    endtask

    task automatic req(input logic we, input logic re, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic rst);
        @(posedge clock);
        m_known = n_known; m_valid = n_valid; m_fault = n_fault;
        m_dout = n_dout; m_wd = n_wd; m_wc = n_wc;
        #1;
        reset = rst; dmemwe = we; dmemre = re; dmemop = op; dmemaddr = a; dmemdatain = d;
        #1;
        if (m_known) begin
            check32("dmemvalid", {31'b0, dmemvalid}, {31'b0, m_valid & ~rst});
            check32("fault", {31'b0, fault}, {31'b0, m_fault & ~rst});
            check32("dmemdataout", dmemdataout, m_dout);
            check32("watchdata", watchdata, m_wd);
            check32("watchcount", {16'h0, watchcount}, {16'h0, m_wc});
        end
        model_step(we, re, op, a, d, rst);
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        req(1'b1, 1'b0, op, a, d, 1'b0);
    endtask

    task automatic ld_lit(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] lit);
        req(1'b0, 1'b1, op, a, 32'h0, 1'b0);
        idle();
        check32(name, dmemdataout, lit);
        check32({name, "_model"}, m_dout, lit);
        check32({name, "_valid"}, {31'b0, dmemvalid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; dmemwe = 1'b0; dmemre = 1'b0; dmemop = 3'b000;
        dmemaddr = 32'h0; dmemdatain = 32'h0;

        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        idle();
        check32("rst_valid", {31'b0, dmemvalid}, 32'd0);
        check32("rst_fault", {31'b0, fault}, 32'd0);
        check32("rst_wd", watchdata, 32'h0);
        check32("rst_wc", {16'h0, watchcount}, 32'h0);
        check32("rst_dout", dmemdataout, 32'h0);

        st(3'b010, 32'h10, 32'h8765_4321);
        ld_lit("lw10", 3'b010, 32'h10, 32'h8765_4321);
        ld_lit("lb13", 3'b000, 32'h13, 32'hFFFF_FF87);
        ld_lit("lbu13", 3'b100, 32'h13, 32'h0000_0087);
        ld_lit("lh12", 3'b001, 32'h12, 32'hFFFF_8765);
        ld_lit("lhu10", 3'b101, 32'h10, 32'h0000_4321);

        st(3'b000, 32'h11, 32'h0000_00AA);
        ld_lit("lw_after_sb", 3'b010, 32'h10, 32'h8765_AA21);
        st(3'b001, 32'h12, 32'h0000_1234);
        ld_lit("lw_after_sh", 3'b010, 32'h10, 32'h1234_AA21);

        req(1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 1'b0);
        idle();
        check32("mis_lw_fault", {31'b0, fault}, 32'd1);
        check32("mis_lw_valid", {31'b0, dmemvalid}, 32'd1);
        check32("mis_lw_dout", dmemdataout, 32'h0);
        st(3'b001, 32'h11, 32'h0000_BEEF);
        idle();
        check32("mis_sh_fault", {31'b0, fault}, 32'd1);
        check32("mis_sh_valid", {31'b0, dmemvalid}, 32'd0);
        req(1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 1'b0);
        idle();
        check32("op011_fault", {31'b0, fault}, 32'd1);
        st(3'b101, 32'h0, 32'h0000_0055);
        idle();
        check32("sw101_fault", {31'b0, fault}, 32'd1);
        check32("sw101_wc", {16'h0, watchcount}, 32'h0);
        ld_lit("lw10_unchanged", 3'b010, 32'h10, 32'h1234_AA21);

        st(3'b010, 32'h0, 32'd100);
        idle();
        check32("watch_wd1", watchdata, 32'd100);
        check32("watch_wc1", {16'h0, watchcount}, 32'd1);
        st(3'b010, 32'h0, 32'd20);
        idle();
        check32("watch_wd2", watchdata, 32'd20);
        check32("watch_wc2", {16'h0, watchcount}, 32'd2);
        st(3'b000, 32'h1, 32'h0000_00FF);
        idle();
        check32("watch_wd3", watchdata, 32'h0000_FF14);
        check32("watch_wc3", {16'h0, watchcount}, 32'd3);

        st(3'b010, 32'h20, 32'd5);
        req(1'b1, 1'b1, 3'b010, 32'h20, 32'd9, 1'b0);
        idle();
        check32("rw_same_old", dmemdataout, 32'd5);
        ld_lit("rw_same_new", 3'b010, 32'h20, 32'd9);

        req(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0);
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        check32("rst_drop_valid", {31'b0, dmemvalid}, 32'd0);
        idle();
        check32("rst_drop_valid2", {31'b0, dmemvalid}, 32'd0);
        check32("rst_drop_dout", dmemdataout, 32'h0);

        for (int i = 0; i < 64; i++) st(3'b010, 32'(i * 4), $urandom);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, a, $urandom,
                ($urandom_range(0, 99) == 0));
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
